// File: rtl/arm_mc_ctrl_hs_if.sv
// Control/handshake bundle between the multi-cycle ARM controller and its datapath/memory.
// The controller uses the master view; the datapath/memory side uses the slave view.
interface arm_mc_ctrl_hs_if #(
   parameter int unsigned ALU_CTRL_W = 3
);
   logic [15:0]           i_Instr;
   logic [3:0]            i_ALU_Flags;
   logic                  i_MemReady;
   logic                  o_MemReq;
   logic                  o_MemWrite;
   logic                  o_AddrSrc;
   logic                  o_PC_Write;
   logic                  o_InstrWrite;
   logic                  o_RegWrite;
   logic [1:0]            o_RegSrc;
   logic [1:0]            o_ImmSrc;
   logic                  o_ALU_SrcA;
   logic [1:0]            o_ALU_SrcB;
   logic [ALU_CTRL_W-1:0] o_ALU_Control;
   logic [1:0]            o_ResultSrc;
   logic [3:0]            o_Flags;
   logic                  o_BusError;

   modport master (
      input  i_Instr, i_ALU_Flags, i_MemReady,
      output o_MemReq, o_MemWrite, o_AddrSrc, o_PC_Write, o_InstrWrite, o_RegWrite,
             o_RegSrc, o_ImmSrc, o_ALU_SrcA, o_ALU_SrcB, o_ALU_Control, o_ResultSrc,
             o_Flags, o_BusError
   );

   modport slave (
      output i_Instr, i_ALU_Flags, i_MemReady,
      input  o_MemReq, o_MemWrite, o_AddrSrc, o_PC_Write, o_InstrWrite, o_RegWrite,
             o_RegSrc, o_ImmSrc, o_ALU_SrcA, o_ALU_SrcB, o_ALU_Control, o_ResultSrc,
             o_Flags, o_BusError
   );
endinterface

// File: rtl/arm_mc_ctrl_hs.sv
// Multi-cycle ARM controller: main FSM, ALU/instruction decode, condition check and NZCV
// register, with a variable-latency memory handshake guarded by a bus-error timeout.
module arm_mc_ctrl_hs #(
   parameter int unsigned ALU_CTRL_W  = 3,
   parameter int unsigned MEM_TIMEOUT = 15,
   parameter logic [3:0]  FLAGS_RST   = 4'b0000
) (
   input logic              i_CLK,
   input logic              i_NRESET,
   arm_mc_ctrl_hs_if.master bus
);

   typedef enum logic [3:0] {
      StFetch, StDecode, StExecReg, StExecImm, StAluWb, StMemAddr,
      StMemRead, StMemWrite, StMemWb, StBranch, StError
   } state_e;

   localparam logic [7:0] TimeoutLast = 8'(MEM_TIMEOUT - 1);

   state_e     state_q, state_d;
   logic [7:0] wait_cnt_q, wait_cnt_d;
   logic [3:0] flags_q, flags_d;
   logic       cond_q, cond_d;

   logic [3:0] cond;
   logic [1:0] op;
   logic [5:0] funct;
   logic [3:0] rd;
   assign {cond, op, funct, rd} = bus.i_Instr;

   // ALU command decode
   logic                  cmd_valid, cmd_arith, cmd_no_wb, flag_we;
   logic [ALU_CTRL_W-1:0] cmd_alu;

   always_comb begin
      cmd_valid = 1'b1;
      cmd_arith = 1'b0;
      cmd_no_wb = 1'b0;
      cmd_alu   = '0;
      case (funct[4:1])
         4'b0100: begin cmd_alu = ALU_CTRL_W'(0); cmd_arith = 1'b1; end
         4'b0010: begin cmd_alu = ALU_CTRL_W'(1); cmd_arith = 1'b1; end
         4'b0000: cmd_alu = ALU_CTRL_W'(2);
         4'b1100: cmd_alu = ALU_CTRL_W'(3);
         4'b0001: cmd_alu = ALU_CTRL_W'(4);
         4'b1101: cmd_alu = ALU_CTRL_W'(5);
         4'b1010: begin cmd_alu = ALU_CTRL_W'(1); cmd_arith = 1'b1; cmd_no_wb = 1'b1; end
         4'b1000: begin cmd_alu = ALU_CTRL_W'(2); cmd_no_wb = 1'b1; end
         default: cmd_valid = 1'b0;
      endcase
      // Compares always update flags; everything else only with S set.
      flag_we = cmd_valid & (cmd_no_wb | funct[0]);
   end

   // Condition check against the architectural flags
   logic cond_pass;
   logic fn, fz, fc, fv;
   assign {fn, fz, fc, fv} = flags_q;

   always_comb begin
      cond_pass = 1'b0;
      case (cond)
         4'b0000: cond_pass = fz;
         4'b0001: cond_pass = ~fz;
         4'b0010: cond_pass = fc;
         4'b0011: cond_pass = ~fc;
         4'b0100: cond_pass = fn;
         4'b0101: cond_pass = ~fn;
         4'b0110: cond_pass = fv;
         4'b0111: cond_pass = ~fv;
         4'b1000: cond_pass = fc & ~fz;
         4'b1001: cond_pass = ~fc | fz;
         4'b1010: cond_pass = (fn == fv);
         4'b1011: cond_pass = (fn != fv);
         4'b1100: cond_pass = ~fz & (fn == fv);
         4'b1101: cond_pass = fz | (fn != fv);
         4'b1110: cond_pass = 1'b1;
         default: cond_pass = 1'b0;
      endcase
   end

   logic                  mem_req, mem_write, addr_src, pc_write, instr_write, reg_write;
   logic                  alu_src_a, bus_error;
   logic [1:0]            alu_src_b, result_src;
   logic [ALU_CTRL_W-1:0] alu_ctrl;

   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = 8'd0;
      flags_d     = flags_q;
      cond_d      = cond_q;
      mem_req     = 1'b0;
      mem_write   = 1'b0;
      addr_src    = 1'b0;
      pc_write    = 1'b0;
      instr_write = 1'b0;
      reg_write   = 1'b0;
      alu_src_a   = 1'b0;
      alu_src_b   = 2'b00;
      result_src  = 2'b00;
      alu_ctrl    = '0;
      bus_error   = 1'b0;
      unique case (state_q)
         StFetch: begin
            mem_req    = 1'b1;
            alu_src_a  = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            if (bus.i_MemReady) begin
               instr_write = 1'b1;
               pc_write    = 1'b1;
               state_d     = StDecode;
            end else if (wait_cnt_q == TimeoutLast) begin
               state_d = StError;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end
         StDecode: begin
            alu_src_a  = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            cond_d     = cond_pass;
            if (!cond_pass) begin
               state_d = StFetch;
            end else begin
               case (op)
                  2'b00:   state_d = !cmd_valid ? StFetch : (funct[5] ? StExecImm : StExecReg);
                  2'b01:   state_d = StMemAddr;
                  2'b10:   state_d = StBranch;
                  default: state_d = StFetch;
               endcase
            end
         end
         StExecReg, StExecImm: begin
            alu_src_b = (state_q == StExecImm) ? 2'b01 : 2'b00;
            alu_ctrl  = cmd_alu;
            // Logical ops leave C and V untouched.
            if (cond_q && flag_we) begin
               flags_d = cmd_arith ? bus.i_ALU_Flags : {bus.i_ALU_Flags[3:2], flags_q[1:0]};
            end
            state_d = cmd_no_wb ? StFetch : StAluWb;
         end
         StAluWb: begin
            reg_write = 1'b1;
            pc_write  = (rd == 4'd15);
            state_d   = StFetch;
         end
         StMemAddr: begin
            alu_src_b = 2'b01;
            state_d   = funct[0] ? StMemRead : StMemWrite;
         end
         StMemRead, StMemWrite: begin
            mem_req   = 1'b1;
            mem_write = (state_q == StMemWrite);
            addr_src  = 1'b1;
            if (bus.i_MemReady) begin
               state_d = (state_q == StMemRead) ? StMemWb : StFetch;
            end else if (wait_cnt_q == TimeoutLast) begin
               state_d = StError;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end
         StMemWb: begin
            reg_write  = 1'b1;
            result_src = 2'b01;
            pc_write   = (rd == 4'd15);
            state_d    = StFetch;
         end
         StBranch: begin
            alu_src_a  = 1'b1;
            alu_src_b  = 2'b01;
            result_src = 2'b10;
            pc_write   = 1'b1;
            state_d    = StFetch;
         end
         StError: bus_error = 1'b1;
         default: state_d = StError;
      endcase
   end

   always_ff @(posedge i_CLK or negedge i_NRESET) begin
      if (!i_NRESET) begin
         state_q    <= StFetch;
         wait_cnt_q <= 8'd0;
         flags_q    <= FLAGS_RST;
         cond_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         flags_q    <= flags_d;
         cond_q     <= cond_d;
      end
   end

   // Outputs are forced low combinationally so an access aborts the moment reset asserts.
   assign bus.o_MemReq      = i_NRESET & mem_req;
   assign bus.o_MemWrite    = i_NRESET & mem_write;
   assign bus.o_AddrSrc     = i_NRESET & addr_src;
   assign bus.o_PC_Write    = i_NRESET & pc_write;
   assign bus.o_InstrWrite  = i_NRESET & instr_write;
   assign bus.o_RegWrite    = i_NRESET & reg_write;
   assign bus.o_ALU_SrcA    = i_NRESET & alu_src_a;
   assign bus.o_BusError    = i_NRESET & bus_error;
   assign bus.o_ALU_SrcB    = i_NRESET ? alu_src_b : 2'b00;
   assign bus.o_ResultSrc   = i_NRESET ? result_src : 2'b00;
   assign bus.o_ALU_Control = i_NRESET ? alu_ctrl : '0;
   assign bus.o_RegSrc      = i_NRESET ? {op == 2'b01, op == 2'b10} : 2'b00;
   assign bus.o_ImmSrc      = i_NRESET ? op : 2'b00;
   assign bus.o_Flags       = i_NRESET ? flags_q : 4'b0000;

endmodule

// File: tb/tb_arm_mc_ctrl_hs.sv
// Directed bench for arm_mc_ctrl_hs: walks instructions cycle by cycle and compares the
// strobe bundle against hand-written per-state signatures.
module tb_arm_mc_ctrl_hs;

   logic clk = 1'b0;
   logic nreset;
   always #5 clk = ~clk;

   arm_mc_ctrl_hs_if #(.ALU_CTRL_W(3)) bus ();

   arm_mc_ctrl_hs #(
      .ALU_CTRL_W (3),
      .MEM_TIMEOUT(15),
      .FLAGS_RST  (4'b0000)
   ) dut (
      .i_CLK   (clk),
      .i_NRESET(nreset),
      .bus     (bus)
   );

   // {req, wr, addr, pcw, irw, regw, srca, srcb[1:0], ressrc[1:0], alu[2:0], berr}
   logic [14:0] outs;
   assign outs = {bus.o_MemReq, bus.o_MemWrite, bus.o_AddrSrc, bus.o_PC_Write,
                  bus.o_InstrWrite, bus.o_RegWrite, bus.o_ALU_SrcA, bus.o_ALU_SrcB,
                  bus.o_ResultSrc, bus.o_ALU_Control, bus.o_BusError};

   localparam logic [14:0] FetchWait = 15'b1_0_0_0_0_0_1_10_10_000_0;
   localparam logic [14:0] FetchGo   = 15'b1_0_0_1_1_0_1_10_10_000_0;
   localparam logic [14:0] Decode    = 15'b0_0_0_0_0_0_1_10_10_000_0;
   localparam logic [14:0] ExrAdd    = 15'b0_0_0_0_0_0_0_00_00_000_0;
   localparam logic [14:0] ExrSub    = 15'b0_0_0_0_0_0_0_00_00_001_0;
   localparam logic [14:0] ExrEor    = 15'b0_0_0_0_0_0_0_00_00_100_0;
   localparam logic [14:0] ExiMov    = 15'b0_0_0_0_0_0_0_01_00_101_0;
   localparam logic [14:0] AluWb     = 15'b0_0_0_0_0_1_0_00_00_000_0;
   localparam logic [14:0] AluWbPc   = 15'b0_0_0_1_0_1_0_00_00_000_0;
   localparam logic [14:0] MemAddr   = 15'b0_0_0_0_0_0_0_01_00_000_0;
   localparam logic [14:0] MemRead   = 15'b1_0_1_0_0_0_0_00_00_000_0;
   localparam logic [14:0] MemWrite  = 15'b1_1_1_0_0_0_0_00_00_000_0;
   localparam logic [14:0] MemWb     = 15'b0_0_0_0_0_1_0_00_01_000_0;
   localparam logic [14:0] Branch    = 15'b0_0_0_1_0_0_1_01_10_000_0;
   localparam logic [14:0] ErrorSig  = 15'b0_0_0_0_0_0_0_00_00_000_1;

   int n_chk;
   int n_pass;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // Drive ready, check the current cycle's outputs, then advance past the next edge.
   task automatic cyc(input string tag, input logic ready, input logic [14:0] exp);
      bus.i_MemReady = ready;
      #1;
      chk(tag, 32'(outs), 32'(exp));
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_chk = 0;
      n_pass = 0;
      nreset = 1'b0;
      bus.i_Instr = 16'h0000;
      bus.i_ALU_Flags = 4'b0000;
      bus.i_MemReady = 1'b0;
      #3;
      chk("rst_outs", 32'(outs), 32'd0);
      chk("rst_flags", 32'(bus.o_Flags), 32'd0);
      @(negedge clk);
      nreset = 1'b1;
      #1;

      // ADDS R1,R2,R3
      bus.i_Instr = {4'b1110, 2'b00, 6'b001001, 4'd1};
      bus.i_ALU_Flags = 4'b0100;
      cyc("adds_fetch", 1'b1, FetchGo);
      cyc("adds_decode", 1'b1, Decode);
      chk("adds_flags_pre", 32'(bus.o_Flags), 32'h0);
      cyc("adds_exec", 1'b1, ExrAdd);
      chk("adds_flags", 32'(bus.o_Flags), 32'h4);
      cyc("adds_wb", 1'b1, AluWb);

      // LDR with two wait cycles
      bus.i_Instr = {4'b1110, 2'b01, 6'b000001, 4'd2};
      cyc("ldr_fetch", 1'b1, FetchGo);
      chk("ldr_regsrc", 32'(bus.o_RegSrc), 32'h2);
      chk("ldr_immsrc", 32'(bus.o_ImmSrc), 32'h1);
      cyc("ldr_decode", 1'b1, Decode);
      cyc("ldr_memaddr", 1'b1, MemAddr);
      cyc("ldr_rd_w1", 1'b0, MemRead);
      cyc("ldr_rd_w2", 1'b0, MemRead);
      cyc("ldr_rd_go", 1'b1, MemRead);
      cyc("ldr_memwb", 1'b1, MemWb);

      // CMP setting Z, then BEQ taken
      bus.i_Instr = {4'b1110, 2'b00, 6'b010100, 4'd0};
      bus.i_ALU_Flags = 4'b0100;
      cyc("cmpz_fetch", 1'b1, FetchGo);
      cyc("cmpz_decode", 1'b1, Decode);
      cyc("cmpz_exec", 1'b1, ExrSub);
      chk("cmpz_flags", 32'(bus.o_Flags), 32'h4);
      bus.i_Instr = {4'b0000, 2'b10, 6'b000000, 4'd0};
      cyc("beq_t_fetch", 1'b1, FetchGo);
      cyc("beq_t_decode", 1'b1, Decode);
      cyc("beq_t_branch", 1'b1, Branch);

      // CMP clearing Z, then BEQ skipped
      bus.i_Instr = {4'b1110, 2'b00, 6'b010100, 4'd0};
      bus.i_ALU_Flags = 4'b0000;
      cyc("cmpnz_fetch", 1'b1, FetchGo);
      cyc("cmpnz_decode", 1'b1, Decode);
      cyc("cmpnz_exec", 1'b1, ExrSub);
      chk("cmpnz_flags", 32'(bus.o_Flags), 32'h0);
      bus.i_Instr = {4'b0000, 2'b10, 6'b000000, 4'd0};
      cyc("beq_n_fetch", 1'b1, FetchGo);
      cyc("beq_n_decode", 1'b1, Decode);
      cyc("beq_n_skip", 1'b0, FetchWait);
      cyc("beq_n_refetch", 1'b1, FetchGo);

      // CMP sets C,V; EORS then updates only N,Z
      bus.i_Instr = {4'b1110, 2'b00, 6'b010100, 4'd0};
      bus.i_ALU_Flags = 4'b0011;
      cyc("cmpcv_decode", 1'b1, Decode);
      cyc("cmpcv_exec", 1'b1, ExrSub);
      chk("cmpcv_flags", 32'(bus.o_Flags), 32'h3);
      bus.i_Instr = {4'b1110, 2'b00, 6'b000011, 4'd4};
      bus.i_ALU_Flags = 4'b1000;
      cyc("eors_fetch", 1'b1, FetchGo);
      cyc("eors_decode", 1'b1, Decode);
      cyc("eors_exec", 1'b1, ExrEor);
      chk("eors_flags", 32'(bus.o_Flags), 32'hB);
      cyc("eors_wb", 1'b1, AluWb);

      // MOV R15, #imm without S: RegWrite and PC_Write together, flags kept
      bus.i_Instr = {4'b1110, 2'b00, 6'b111010, 4'd15};
      bus.i_ALU_Flags = 4'b0100;
      cyc("mov_fetch", 1'b1, FetchGo);
      cyc("mov_decode", 1'b1, Decode);
      cyc("mov_exec", 1'b1, ExiMov);
      chk("mov_flags", 32'(bus.o_Flags), 32'hB);
      cyc("mov_wb_pc", 1'b1, AluWbPc);

      // STR interrupted by reset during the write wait
      bus.i_Instr = {4'b1110, 2'b01, 6'b000000, 4'd3};
      cyc("str_fetch", 1'b1, FetchGo);
      cyc("str_decode", 1'b1, Decode);
      cyc("str_memaddr", 1'b1, MemAddr);
      cyc("str_wait", 1'b0, MemWrite);
      bus.i_MemReady = 1'b0;
      #1;
      chk("str_wait2", 32'(outs), 32'(MemWrite));
      nreset = 1'b0;
      #1;
      chk("str_rst_outs", 32'(outs), 32'd0);
      chk("str_rst_flags", 32'(bus.o_Flags), 32'd0);
      bus.i_Instr = {4'b1111, 2'b00, 6'b001001, 4'd1};
      @(negedge clk);
      nreset = 1'b1;
      #1;
      chk("post_rst_flags", 32'(bus.o_Flags), 32'h0);
      cyc("post_rst_fetch", 1'b1, FetchGo);
      cyc("nv_decode", 1'b1, Decode);

      // Ready on the last allowed wait cycle completes normally
      for (int i = 0; i < 14; i++) cyc("to_ok_wait", 1'b0, FetchWait);
      cyc("to_ok_ready", 1'b1, FetchGo);
      cyc("to_ok_decode", 1'b1, Decode);

      // No ready: fifteen wait cycles then a sticky bus error
      for (int i = 0; i < 15; i++) cyc("to_err_wait", 1'b0, FetchWait);
      for (int i = 0; i < 22; i++) cyc("to_err_sticky", 1'(i % 2), ErrorSig);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/arm_mc_ctrl_hs.md
Name: arm_mc_ctrl_hs

Overview:
Second-generation multi-cycle ARM controller: main FSM, ALU decoder, instruction decoder and condition/flag logic in one block.
Adds a variable-latency memory handshake (o_MemReq/i_MemReady) with a bus-error timeout, a parametrised ALU control width, EOR/TST/MOV support and early condition-fail skip.
Drives the existing multi-cycle datapath: PC, IR, register file, extender, ALU muxes and result mux.

Parameters:
ALU_CTRL_W, 3, width of o_ALU_Control; must be >= 3.
MEM_TIMEOUT, 15, maximum wait cycles without i_MemReady before bus error (1..255).
FLAGS_RST, 4'b0000, NZCV value loaded at reset.

Ports:
i_CLK  in  1  clock
i_NRESET  in  1  async active-low reset
i_Instr  in  16  {Cond[15:12], Op[11:10], Funct[9:4], Rd[3:0]}
i_ALU_Flags  in  4  ALU NZCV
i_MemReady  in  1  memory completes the current request this cycle
o_MemReq  out  1  memory access request
o_MemWrite  out  1  write strobe, valid with o_MemReq
o_AddrSrc  out  1  0=PC, 1=ALUOut
o_PC_Write  out  1  PC load enable
o_InstrWrite  out  1  IR load enable
o_RegWrite  out  1  register file write
o_RegSrc  out  2  [1]=(Op==01), [0]=(Op==10)
o_ImmSrc  out  2  equals Op
o_ALU_SrcA  out  1  0=RD1, 1=PC
o_ALU_SrcB  out  2  00=RD2, 01=Imm, 10=const 4
o_ALU_Control  out  ALU_CTRL_W  0 ADD, 1 SUB, 2 AND, 3 ORR, 4 EOR, 5 PASSB
o_ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
o_Flags  out  4  current NZCV register
o_BusError  out  1  sticky timeout indication

Behaviour:
- Reset: i_NRESET is asynchronous, active-low, on clock i_CLK. Reset forces state FETCH, flags=FLAGS_RST, wait counter=0, o_BusError=0, CondQ=0. All outputs are 0 while i_NRESET is low, o_MemReq included.
- Unlisted outputs are 0 in every state; don't-cares are driven 0.
- FETCH: o_MemReq=1, AddrSrc=0, SrcA=1, SrcB=10, ResultSrc=10, ALU ADD. When i_MemReady=1: InstrWrite=1, PC_Write=1, next state DECODE. Otherwise stay in FETCH.
- DECODE: SrcA=1, SrcB=10, ResultSrc=10. Evaluate the condition against o_Flags using standard ARM EQ..AL encoding; Cond=1111 fails. Latch the result into CondQ.
  - Condition fails: go to FETCH; no write strobes.
  - Op=00 with Funct[5]=1: EXEC_IMM; with Funct[5]=0: EXEC_REG.
  - Op=00 with unsupported cmd: FETCH (NOP).
  - Op=01: MEMADDR. Op=10: BRANCH. Op=11: FETCH.
- EXEC_REG / EXEC_IMM: SrcA=0, SrcB=00 or 01, ALU control from the command decode. If CondQ=1 and the flag write is enabled, flags update at the clock edge. Next state ALUWB, or FETCH for CMP/TST.
- ALU command decode (Funct[4:1]):
  - 0100 ADD → 0; 0010 SUB → 1; 0000 AND → 2; 1100 ORR → 3; 0001 EOR → 4; 1101 MOV → 5.
  - 1010 CMP → 1, no write. 1000 TST → 2, no write.
- Flag write rules:
  - Arithmetic ops (ADD, SUB, CMP) write NZCV; logical ops (AND, ORR, EOR, TST, MOV) write NZ only.
  - S bit (Funct[0]) gates the write, except CMP/TST, which always write.
- ALUWB: RegWrite=1, ResultSrc=00. If Rd=15, PC_Write=1 in the same cycle. Next state FETCH.
- MEMADDR: SrcA=0, SrcB=01, ALU ADD. Funct[0]=1 → MEMREAD, else MEMWRITE.
- MEMREAD: o_MemReq=1, AddrSrc=1. On i_MemReady go to MEMWB.
- MEMWRITE: o_MemReq=1, o_MemWrite=1, AddrSrc=1. On i_MemReady go to FETCH.
- MEMWB: RegWrite=1, ResultSrc=01. If Rd=15, PC_Write=1. Next state FETCH.
- BRANCH: SrcA=1, SrcB=01, ResultSrc=10, PC_Write=1. Next state FETCH.
- Wait counter (8 bit):
  - Cleared on entry to any request state and on every i_MemReady. Increments each request cycle with i_MemReady=0.
  - When the count reaches MEM_TIMEOUT with i_MemReady still 0 → state ERROR.
  - i_MemReady arriving in the same cycle as the limit wins: the transfer completes normally.
- ERROR: all strobes 0, o_BusError=1. Only exit is reset.
- Reset mid-access aborts immediately; no write strobe is issued after reset deasserts until a new FETCH completes.

Test Plan:
1. ADDS R1,R2,R3 (Cond=1110, Op=00, Funct=001001), i_MemReady always 1, ALU flags 0100 → states FETCH,DECODE,EXEC_REG,ALUWB over 4 cycles; RegWrite=1 in cycle 4 only; o_Flags=0100 after EXEC.
2. LDR (Op=01, Funct[0]=1), ready low 2 cycles in MEMREAD → MEMREAD lasts 3 cycles, MemWB RegWrite=1 with ResultSrc=01; total 7 cycles.
3. CMP setting Z=1, then BEQ (Cond=0000, Op=10) → BRANCH reached, PC_Write=1. Repeat with Z=0 → DECODE→FETCH, no PC_Write beyond fetch.
4. MOV R15 via ALUWB (Rd=15) → RegWrite=1 and PC_Write=1 in the same cycle.
5. Hold i_MemReady=0 in FETCH with MEM_TIMEOUT=15 → ERROR after 15 wait cycles, o_BusError=1 held for 20+ cycles. Ready exactly at cycle 15 → normal DECODE, no error.
6. Assert i_NRESET low during MEMWRITE wait → o_MemReq/o_MemWrite drop asynchronously, flags=FLAGS_RST; after release the first strobe is FETCH o_MemReq with AddrSrc=0.
